alu_sched: RTL and testbench
============================

Name: alu_sched

Overview:
- Sequencer/arbiter sharing one ALU instance (N-bit, 4-bit opcode, 5 flags, MUL/DIV start/finished handshake) between two requesters: port 0 (CPU execute stage) and port 1 (coprocessor/DMA checksum unit).
- Owns the ALU operand, opcode and start inputs.
- Runs single-cycle ops, the MUL op and the multi-cycle DIV handshake, including DIV timeout.
- Returns result, high, flags and completion to the granted requester.

Parameters:
- N, 32, datapath width
- ALU_OP_COUNT, 4, opcode width
- FLAGS_COUNT, 5, flag width (bit4 GE, bit3 POS, bit2 OVF, bit1 CARRY, bit0 ZERO)
- DIV_TIMEOUT, 64, maximum DIV_WAIT cycles before abort

Ports:
- CLK  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req0_valid, req1_valid  in  1  request, held until matching done
- req0_op, req1_op  in  ALU_OP_COUNT  opcode (1..11 legal)
- req0_a, req0_b, req1_a, req1_b  in  N  operands, stable while valid
- req0_uns, req1_uns  in  1  unsigned select
- req0_done, req1_done  out  1  one-cycle completion pulse
- rsp_result, rsp_high  out  N  registered result / MUL upper word or DIV remainder
- rsp_flags  out  FLAGS_COUNT  registered flags
- rsp_err  out  1  illegal opcode or DIV timeout, valid with done
- busy  out  1  state != IDLE
- alu_a, alu_b  out  N  to ALU
- alu_opcode  out  ALU_OP_COUNT  to ALU; 0 when idle
- alu_uns, alu_start  out  1  to ALU
- alu_result, alu_high  in  N  from ALU
- alu_flags  in  FLAGS_COUNT  from ALU
- alu_finished  in  1  from ALU

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0, including alu_opcode=0, so the ALU holds its value. Timeout counter 0, grant pointer 0. An op in flight is abandoned and no done is issued; requesters re-present after reset.
- States: IDLE, EXEC, CAPT, DIV_START, DIV_WAIT, RESP.
- IDLE, on any valid: arbitrate (fixed priority, port 0 wins). Register the winner's op/a/b/uns into alu_* and latch grant id.
  - Legal op, not DIV: go to EXEC.
  - DIV: go to DIV_START.
  - Op 0 or >11: go to RESP with err=1, result/high/flags 0.
- EXEC (1 cycle): ALU updates its registered result on this edge. Next state CAPT.
- CAPT: register alu_result/flags into rsp_*.
  - rsp_high captured only for MUL (op 3); otherwise 0.
  - Next state RESP.
- DIV_START: alu_start=1 for exactly one cycle. Next state DIV_WAIT.
- DIV_WAIT: alu_start=0 and alu_opcode held at DIV.
  - alu_finished is ignored in the first DIV_WAIT cycle (stale value).
  - Afterwards, alu_finished=1: capture result/high/flags, go to RESP.
  - Counter increments each DIV_WAIT cycle. When the count reaches DIV_TIMEOUT without finished: go to RESP with err=1, result/high 0.
  - A finished seen on the same cycle the count reaches DIV_TIMEOUT takes priority over the timeout.
- RESP: pulse the granted reqN_done for 1 cycle; rsp_* valid this cycle and held until the next capture. alu_opcode returns to 0. Next state IDLE.
- Latency from valid sampled in IDLE to done:
  - single-cycle ops and MUL: 4 cycles
  - illegal op: 2 cycles
  - DIV: 4 + finish cycles
- Back-to-back: a requester may deassert valid in the done cycle. If it stays high, it is re-arbitrated in the next IDLE cycle.
- A valid asserted while busy waits; it is never dropped or overwritten.
- Operands are sampled once at grant; changes afterwards are ignored.

Optional Feature:
- Macro ALU_SCHED_RR_EN.
  - Defined: round-robin arbitration. The grant pointer toggles after each completion; on simultaneous requests, the port not served last wins.
  - Undefined: fixed priority, port 0 always wins; port 1 can starve.

Test Plan:
- req0 ADD a=5, b=7, uns=0 -> req0_done 4 cycles after grant. rsp_result=12, ZERO=0, POS=1, err=0; req1_done stays 0.
- req1 MUL a=0x10000, b=0x10000 -> rsp_result=0, rsp_high=1, req1_done pulses once. alu_start never asserted.
- req0 DIV a=100, b=7, model finishes after 33 cycles -> alu_start high exactly 1 cycle. rsp_result=14, rsp_high=2, err=0.
- Both valid same cycle with SUB, repeated 4 times:
  - RR_EN undefined -> grants 0,0,0,0.
  - RR_EN defined -> grants 0,1,0,1.
- DIV with alu_finished never asserted -> done after DIV_TIMEOUT=64 wait cycles with err=1, result 0. Also req0 op=13 -> done after 2 cycles with err=1.
- rst pulled low during DIV_WAIT -> all outputs 0 immediately, no done. After release, a fresh AND 0xF0 & 0x3C completes with 0x30.

Source files
------------

// File: rtl/alu_sched_if.sv
// Requester, response and ALU-side signals of the alu_sched shared-ALU sequencer.
// slave is the scheduler's view; master is the view of the requesters and the ALU.
interface alu_sched_if #(
   parameter int N            = 32,
   parameter int ALU_OP_COUNT = 4,
   parameter int FLAGS_COUNT  = 5
);
   logic                    req0_valid, req1_valid;
   logic [ALU_OP_COUNT-1:0] req0_op, req1_op;
   logic [N-1:0]            req0_a, req0_b, req1_a, req1_b;
   logic                    req0_uns, req1_uns;
   logic                    req0_done, req1_done;
   logic [N-1:0]            rsp_result, rsp_high;
   logic [FLAGS_COUNT-1:0]  rsp_flags;
   logic                    rsp_err;
   logic                    busy;
   logic [N-1:0]            alu_a, alu_b;
   logic [ALU_OP_COUNT-1:0] alu_opcode;
   logic                    alu_uns, alu_start;
   logic [N-1:0]            alu_result, alu_high;
   logic [FLAGS_COUNT-1:0]  alu_flags;
   logic                    alu_finished;

   modport slave (
      input  req0_valid, req1_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b,
             req0_uns, req1_uns, alu_result, alu_high, alu_flags, alu_finished,
      output req0_done, req1_done, rsp_result, rsp_high, rsp_flags, rsp_err, busy,
             alu_a, alu_b, alu_opcode, alu_uns, alu_start
   );

   modport master (
      output req0_valid, req1_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b,
             req0_uns, req1_uns, alu_result, alu_high, alu_flags, alu_finished,
      input  req0_done, req1_done, rsp_result, rsp_high, rsp_flags, rsp_err, busy,
             alu_a, alu_b, alu_opcode, alu_uns, alu_start
   );
endinterface

// File: rtl/alu_sched.sv
// Two-port sequencer sharing one ALU: single-cycle ops, MUL, and DIV start/finished with timeout.
// Define ALU_SCHED_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module alu_sched #(
   parameter int N            = 32,
   parameter int ALU_OP_COUNT = 4,
   parameter int FLAGS_COUNT  = 5,
   parameter int DIV_TIMEOUT  = 64
) (
   input logic        CLK,
   input logic        rst,
   alu_sched_if.slave bus
);
   localparam int CW = $clog2(DIV_TIMEOUT + 1);
   typedef logic [ALU_OP_COUNT-1:0] op_t;
   localparam op_t OP_MUL  = op_t'(3);
   localparam op_t OP_DIV  = op_t'(4);
   localparam op_t OP_LAST = op_t'(11);

   typedef enum logic [2:0] {
      S_IDLE, S_EXEC, S_CAPT, S_DIV_START, S_DIV_WAIT, S_RESP
   } state_e;

   state_e                 state_q, state_d;
   logic                   grant_q, grant_d;
   op_t                    op_q, op_d;
   logic [N-1:0]           a_q, a_d, b_q, b_d;
   logic                   uns_q, uns_d;
   logic [N-1:0]           result_q, result_d, high_q, high_d;
   logic [FLAGS_COUNT-1:0] flags_q, flags_d;
   logic                   err_q, err_d;
   logic [CW-1:0]          cnt_q, cnt_d;

   logic pick1;
`ifdef ALU_SCHED_RR_EN
   logic ptr_q, ptr_d;
   // ptr_q names the port preferred when both request: the one not served last.
   assign pick1 = bus.req1_valid & (~bus.req0_valid | ptr_q);
`else
   assign pick1 = bus.req1_valid & ~bus.req0_valid;
`endif

   op_t  sel_op;
   logic sel_legal;
   assign sel_op    = pick1 ? bus.req1_op : bus.req0_op;
   assign sel_legal = (sel_op != '0) && (sel_op <= OP_LAST);

   // NOTE: every _d gets its default first, so no path through the case can infer a latch.
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      uns_d    = uns_q;
      result_d = result_q;
      high_d   = high_q;
      flags_d  = flags_q;
      err_d    = err_q;
      cnt_d    = cnt_q;
`ifdef ALU_SCHED_RR_EN
      ptr_d    = ptr_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (bus.req0_valid || bus.req1_valid) begin
               grant_d = pick1;
               a_d     = pick1 ? bus.req1_a : bus.req0_a;
               b_d     = pick1 ? bus.req1_b : bus.req0_b;
               uns_d   = pick1 ? bus.req1_uns : bus.req0_uns;
               if (sel_legal) begin
                  op_d    = sel_op;
                  state_d = (sel_op == OP_DIV) ? S_DIV_START : S_EXEC;
               end else begin
                  op_d     = '0;
                  result_d = '0;
                  high_d   = '0;
                  flags_d  = '0;
                  err_d    = 1'b1;
                  state_d  = S_RESP;
               end
            end
         end
         S_EXEC:      state_d = S_CAPT;
         S_CAPT: begin
            result_d = bus.alu_result;
            high_d   = (op_q == OP_MUL) ? bus.alu_high : '0;
            flags_d  = bus.alu_flags;
            err_d    = 1'b0;
            op_d     = '0;
            state_d  = S_RESP;
         end
         S_DIV_START: state_d = S_DIV_WAIT;
         S_DIV_WAIT: begin
            cnt_d = cnt_q + CW'(1);
            // finished is stale in the first wait cycle; a late finish beats the timeout.
            if ((cnt_q != '0) && bus.alu_finished) begin
               result_d = bus.alu_result;
               high_d   = bus.alu_high;
               flags_d  = bus.alu_flags;
               err_d    = 1'b0;
               op_d     = '0;
               cnt_d    = '0;
               state_d  = S_RESP;
            end else if (cnt_q == CW'(DIV_TIMEOUT - 1)) begin
               result_d = '0;
               high_d   = '0;
               flags_d  = '0;
               err_d    = 1'b1;
               op_d     = '0;
               cnt_d    = '0;
               state_d  = S_RESP;
            end
         end
         S_RESP: begin
`ifdef ALU_SCHED_RR_EN
            ptr_d = ~grant_q;
`endif
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all of them update together.
   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         grant_q  <= 1'b0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         uns_q    <= 1'b0;
         result_q <= '0;
         high_q   <= '0;
         flags_q  <= '0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
`ifdef ALU_SCHED_RR_EN
         ptr_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         uns_q    <= uns_d;
         result_q <= result_d;
         high_q   <= high_d;
         flags_q  <= flags_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
`ifdef ALU_SCHED_RR_EN
         ptr_q    <= ptr_d;
`endif
      end
   end

   assign bus.req0_done  = (state_q == S_RESP) & ~grant_q;
   assign bus.req1_done  = (state_q == S_RESP) & grant_q;
   assign bus.rsp_result = result_q;
   assign bus.rsp_high   = high_q;
   assign bus.rsp_flags  = flags_q;
   assign bus.rsp_err    = err_q;
   assign bus.busy       = (state_q != S_IDLE);
   assign bus.alu_a      = a_q;
   assign bus.alu_b      = b_q;
   assign bus.alu_opcode = op_q;
   assign bus.alu_uns    = uns_q;
   assign bus.alu_start  = (state_q == S_DIV_START);
endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched: behavioural ALU, request sequencing model, random traffic.
// Expected grant order follows ALU_SCHED_RR_EN when the bench is built with it.
module tb_alu_sched;
   localparam int N = 32, OPW = 4, FW = 5, DIV_TIMEOUT = 64;
   localparam logic [3:0] OP_ADD = 4'd1, OP_SUB = 4'd2, OP_MUL = 4'd3, OP_DIV = 4'd4, OP_AND = 4'd5;
`ifdef ALU_SCHED_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] result;
      logic [31:0] high;
      logic [4:0]  flags;
   } alu_out_t;

   logic CLK = 1'b0;
   logic rst = 1'b0;
   always #5 CLK = ~CLK;

   alu_sched_if #(.N(N), .ALU_OP_COUNT(OPW), .FLAGS_COUNT(FW)) bus ();
   alu_sched #(.N(N), .ALU_OP_COUNT(OPW), .FLAGS_COUNT(FW), .DIV_TIMEOUT(DIV_TIMEOUT)) dut (
      .CLK(CLK), .rst(rst), .bus(bus)
   );

   int vectors = 0;
   int miscompares = 0;
   bit last_served = 1'b1;  // after reset port 0 is preferred

   // Flags: {GE, POS, OVF, CARRY, ZERO}.
   function automatic alu_out_t alu_eval(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                         input logic uns);
      alu_out_t o;
      logic [32:0] s;
      logic [63:0] p;
      logic carry, ovf;
      o = '0; s = '0; p = '0; carry = 1'b0; ovf = 1'b0;
      case (op)
         4'd1: begin s = {1'b0, a} + {1'b0, b}; o.result = s[31:0]; carry = s[32];
                     ovf = (a[31] == b[31]) && (o.result[31] != a[31]); end
         4'd2: begin s = {1'b0, a} - {1'b0, b}; o.result = s[31:0]; carry = s[32];
                     ovf = (a[31] != b[31]) && (o.result[31] != a[31]); end
         4'd3: begin
            if (uns) p = {32'd0, a} * {32'd0, b};
            else     p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            o.result = p[31:0]; o.high = p[63:32];
         end
         4'd4: begin
            if (uns) begin o.result = a / b; o.high = a % b; end
            else begin o.result = $signed(a) / $signed(b); o.high = $signed(a) % $signed(b); end
         end
         4'd5:  o.result = a & b;
         4'd6:  o.result = a | b;
         4'd7:  o.result = a ^ b;
         4'd8:  o.result = a << b[4:0];
         4'd9:  o.result = a >> b[4:0];
         4'd10: o.result = $signed(a) >>> b[4:0];
         4'd11: o.result = {31'd0, uns ? (a < b) : ($signed(a) < $signed(b))};
         default: o.result = '0;
      endcase
      o.flags = {uns ? (a >= b) : ($signed(a) >= $signed(b)),
                 (!o.result[31]) && (o.result != 0), ovf, carry, o.result == 0};
      return o;
   endfunction

   // Behavioural ALU: registered single-cycle result; DIV finishes div_delay edges after start.
   int div_left = 0;
   int div_delay = 1;
   int start_cnt = 0;
   logic [31:0] div_a, div_b;
   logic div_uns;
   always @(posedge CLK) begin : alu_model
      alu_out_t o;
      if (bus.alu_start) begin
         start_cnt <= start_cnt + 1;
         div_left  <= div_delay;
         div_a <= bus.alu_a; div_b <= bus.alu_b; div_uns <= bus.alu_uns;
      end else if (div_left > 0) begin
         div_left <= div_left - 1;
         if (div_left == 1) begin
            o = alu_eval(OP_DIV, div_a, div_b, div_uns);
            bus.alu_finished <= 1'b1;
            bus.alu_result <= o.result; bus.alu_high <= o.high; bus.alu_flags <= o.flags;
         end else begin
            bus.alu_finished <= 1'b0;
         end
      end
      if (bus.alu_opcode != 4'd0 && bus.alu_opcode != OP_DIV) begin
         o = alu_eval(bus.alu_opcode, bus.alu_a, bus.alu_b, bus.alu_uns);
         bus.alu_result <= o.result;
         bus.alu_high   <= (bus.alu_opcode == OP_MUL) ? o.high : (bus.alu_a ^ 32'hDEAD_BEEF);
         bus.alu_flags  <= o.flags;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (bus.busy && n < 200) begin @(negedge CLK); n++; end
      check({tag, "_idle"}, {63'd0, bus.busy}, 64'd0);
      check({tag, "_idle_opcode"}, {60'd0, bus.alu_opcode}, 64'd0);
   endtask

   task automatic drive(input bit port, input logic v, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic uns);
      if (port) begin bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_uns = uns; end
      else      begin bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_uns = uns; end
   endtask

   // One request from idle; latency counted in falling edges after valid is presented.
   task automatic run_req(input bit port, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic uns, input int dly, input string tag);
      alu_out_t e;
      int exp_lat, lat, starts0;
      logic exp_err;
      logic [31:0] er, eh;
      logic [4:0] ef;
      bit got, other;
      e = alu_eval(op, a, b, uns);
      if (op == 4'd0 || op > 4'd11) begin
         exp_lat = 1; exp_err = 1'b1; er = '0; eh = '0; ef = '0;
      end else if (op == OP_DIV && dly > DIV_TIMEOUT - 1) begin
         exp_lat = DIV_TIMEOUT + 2; exp_err = 1'b1; er = '0; eh = '0; ef = '0;
      end else if (op == OP_DIV) begin
         exp_lat = dly + 3; exp_err = 1'b0; er = e.result; eh = e.high; ef = e.flags;
      end else begin
         exp_lat = 3; exp_err = 1'b0; er = e.result; eh = (op == OP_MUL) ? e.high : '0; ef = e.flags;
      end
      wait_idle(tag);
      div_delay = dly;
      starts0 = start_cnt;
      drive(port, 1'b1, op, a, b, uns);
      lat = 0; got = 1'b0; other = 1'b0;
      while (!got && lat < 200) begin
         @(negedge CLK);
         lat++;
         if (port ? bus.req1_done : bus.req0_done) got = 1'b1;
         if (port ? bus.req0_done : bus.req1_done) other = 1'b1;
      end
      check({tag, "_done_seen"}, {63'd0, got}, 64'd1);
      check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      check({tag, "_other_done"}, {63'd0, other}, 64'd0);
      check({tag, "_err"}, {63'd0, bus.rsp_err}, {63'd0, exp_err});
      check({tag, "_result"}, {32'd0, bus.rsp_result}, {32'd0, er});
      check({tag, "_high"}, {32'd0, bus.rsp_high}, {32'd0, eh});
      check({tag, "_flags"}, {59'd0, bus.rsp_flags}, {59'd0, ef});
      check({tag, "_resp_opcode"}, {60'd0, bus.alu_opcode}, 64'd0);
      check({tag, "_starts"}, 64'(start_cnt - starts0), (op == OP_DIV) ? 64'd1 : 64'd0);
      drive(port, 1'b0, op, a, b, uns);
      last_served = port;
      @(negedge CLK);
      check({tag, "_done_pulse"}, {62'd0, bus.req1_done, bus.req0_done}, 64'd0);
      check({tag, "_held"}, {32'd0, bus.rsp_result}, {32'd0, er});
   endtask

   initial begin
      bit w, exp_w, got;
      int n;
      drive(1'b0, 1'b0, 4'd0, '0, '0, 1'b0);
      drive(1'b1, 1'b0, 4'd0, '0, '0, 1'b0);
      #1;
      check("rst_outputs", {bus.req0_done, bus.req1_done, bus.busy, bus.alu_start, bus.alu_uns, bus.rsp_err,
                            bus.alu_opcode, bus.rsp_flags}, 64'd0);
      check("rst_rsp", {bus.rsp_result, bus.rsp_high}, 64'd0);
      check("rst_alu_ab", {bus.alu_a, bus.alu_b}, 64'd0);
      repeat (2) @(negedge CLK);
      rst = 1'b1;
      @(negedge CLK);

      run_req(1'b0, OP_ADD, 32'd5, 32'd7, 1'b0, 1, "add");
      check("add_pos", {63'd0, bus.rsp_flags[3]}, 64'd1);
      check("add_zero", {63'd0, bus.rsp_flags[0]}, 64'd0);
      run_req(1'b0, OP_DIV, 32'd100, 32'd7, 1'b0, 33, "div33");
      run_req(1'b0, OP_DIV, 32'd200, 32'd9, 1'b0, 1, "div_stale");
      run_req(1'b1, OP_MUL, 32'h10000, 32'h10000, 1'b0, 1, "mul");

      // Both ports hold SUB requests; four completions show the arbitration order.
      wait_idle("arb");
      drive(1'b0, 1'b1, OP_SUB, 32'd50, 32'd8, 1'b0);
      drive(1'b1, 1'b1, OP_SUB, 32'd1000, 32'd1, 1'b0);
      for (int k = 0; k < 5; k++) begin
         if (k == 4) drive(1'b0, 1'b0, OP_SUB, 32'd50, 32'd8, 1'b0);
         exp_w = (k == 4) ? 1'b1 : (RR ? ~last_served : 1'b0);
         n = 0; got = 1'b0;
         while (!got && n < 20) begin
            @(negedge CLK); n++;
            got = bus.req0_done | bus.req1_done;
         end
         w = bus.req1_done;
         check($sformatf("arb%0d_done_seen", k), {63'd0, got}, 64'd1);
         check($sformatf("arb%0d_grant", k), {63'd0, w}, {63'd0, exp_w});
         check($sformatf("arb%0d_result", k), {32'd0, bus.rsp_result}, exp_w ? 64'd999 : 64'd42);
         last_served = exp_w;
      end
      drive(1'b1, 1'b0, OP_SUB, 32'd1000, 32'd1, 1'b0);
      @(negedge CLK);

      run_req(1'b0, OP_DIV, 32'd77, 32'd5, 1'b1, DIV_TIMEOUT - 1, "div_edge_finish");
      run_req(1'b0, OP_DIV, 32'd77, 32'd5, 1'b1, DIV_TIMEOUT, "div_edge_timeout");
      run_req(1'b1, OP_DIV, 32'd50, 32'd5, 1'b0, 100000, "div_hang");
      run_req(1'b0, 4'd13, 32'd3, 32'd4, 1'b0, 1, "illegal13");
      run_req(1'b1, 4'd0, 32'd3, 32'd4, 1'b0, 1, "illegal0");

      for (int i = 0; i < 24; i++) begin
         logic [3:0] op;
         logic [31:0] b;
         op = 4'($urandom_range(0, 15));
         b = $urandom();
         if (b == 0) b = 32'd1;
         run_req(1'($urandom_range(0, 1)), op, $urandom(), b, 1'($urandom_range(0, 1)),
                 $urandom_range(1, 40), $sformatf("rnd%0d", i));
      end

      // Asynchronous reset in the middle of a DIV wait abandons the op without a done.
      wait_idle("rst_div");
      div_delay = 100000;
      drive(1'b0, 1'b1, OP_DIV, 32'd1000, 32'd3, 1'b0);
      repeat (10) @(negedge CLK);
      check("rst_div_busy_before", {63'd0, bus.busy}, 64'd1);
      #2 rst = 1'b0;
      #1;
      check("rst_div_ctrl", {bus.req0_done, bus.req1_done, bus.busy, bus.alu_start, bus.alu_uns, bus.rsp_err,
                             bus.alu_opcode, bus.rsp_flags}, 64'd0);
      check("rst_div_rsp", {bus.rsp_result, bus.rsp_high}, 64'd0);
      check("rst_div_alu_ab", {bus.alu_a, bus.alu_b}, 64'd0);
      drive(1'b0, 1'b0, OP_DIV, 32'd1000, 32'd3, 1'b0);
      got = 1'b0;
      repeat (3) begin @(negedge CLK); got = got | bus.req0_done | bus.req1_done; end
      check("rst_div_no_done", {63'd0, got}, 64'd0);
      #2 rst = 1'b1;
      last_served = 1'b1;
      @(negedge CLK);
      run_req(1'b0, OP_AND, 32'hF0, 32'h3C, 1'b0, 1, "and_after_rst");
      check("and_value", {32'd0, bus.rsp_result}, 64'h30);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
